// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: locks one requester onto a shared valid/ready
// stream until its last beat is accepted, then rotates priority past it.
module axis_rr_arbiter #(
   parameter int NREQ   = 4,
   parameter int DWIDTH = 4
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [NREQ*DWIDTH-1:0] i_data,
   input  logic [NREQ-1:0]        i_valid,
   input  logic [NREQ-1:0]        i_last,
   output logic [NREQ-1:0]        o_ready,
   output logic [DWIDTH-1:0]      o_data,
   output logic                   o_valid,
   output logic                   o_last,
   input  logic                   i_ready,
   output logic [NREQ-1:0]        o_grant,
   output logic                   o_busy
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t        state, state_next;
   logic [GW-1:0] g, g_next;
   logic [GW-1:0] p, p_next;
   logic          sel_found;
   logic [GW-1:0] sel_idx;
   logic          accept;

   function automatic logic [GW-1:0] rr_index(input logic [GW-1:0] base, input int offset);
      int sum;
      sum = (int'(base) + offset) % NREQ;
      return sum[GW-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         g     <= '0;
         p     <= GW'(NREQ - 1);
      end else begin
         state <= state_next;
         g     <= g_next;
         p     <= p_next;
      end
   end

   // Search starts just after the last served requester, so it gets lowest priority.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!sel_found && i_valid[rr_index(p, i)]) begin
            sel_found = 1'b1;
            sel_idx   = rr_index(p, i);
         end
      end
   end

   assign accept = (state == LOCKED) && i_valid[g] && i_ready;

   always_comb begin
      state_next = state;
      g_next     = g;
      p_next     = p;
      case (state)
         IDLE: begin
            if (sel_found) begin
               state_next = LOCKED;
               g_next     = sel_idx;
            end
         end
         LOCKED: begin
            if (accept && i_last[g]) begin
               state_next = IDLE;
               p_next     = g;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced low while rstn is held so the bus is quiet during reset.
   always_comb begin
      o_valid = 1'b0;
      o_data  = '0;
      o_last  = 1'b0;
      o_ready = '0;
      o_grant = '0;
      o_busy  = 1'b0;
      if (rstn && state == LOCKED) begin
         o_valid    = i_valid[g];
         o_data     = i_data[g*DWIDTH +: DWIDTH];
         o_last     = i_last[g];
         o_ready[g] = i_ready;
         o_grant[g] = 1'b1;
         o_busy     = 1'b1;
      end
   end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: expected beats are queued as packets are
// offered and checked against every beat the downstream side accepts.
module tb_axis_rr_arbiter;

   localparam int NREQ   = 4;
   localparam int DWIDTH = 4;

   logic                   clk;
   logic                   rstn;
   logic [NREQ*DWIDTH-1:0] i_data;
   logic [NREQ-1:0]        i_valid;
   logic [NREQ-1:0]        i_last;
   logic [NREQ-1:0]        o_ready;
   logic [DWIDTH-1:0]      o_data;
   logic                   o_valid;
   logic                   o_last;
   logic                   i_ready;
   logic [NREQ-1:0]        o_grant;
   logic                   o_busy;

   typedef struct {
      int               req;
      logic [DWIDTH-1:0] data;
      logic             last;
   } beat_t;

   beat_t sb[$];
   int    numChecks = 0;
   int    numFails  = 0;

   axis_rr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_data  (i_data),
      .i_valid (i_valid),
      .i_last  (i_last),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_valid (o_valid),
      .o_last  (o_last),
      .i_ready (i_ready),
      .o_grant (o_grant),
      .o_busy  (o_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic expectBeat(input int req, input logic [DWIDTH-1:0] data, input logic last);
      beat_t b;
      b.req  = req;
      b.data = data;
      b.last = last;
      sb.push_back(b);
   endtask

   // Drive one cycle of inputs, then score any beat the next rising edge will accept.
   task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic rdy);
      beat_t b;
      i_valid = v;
      i_last  = l;
      i_ready = rdy;
      #2;
      if (o_valid && i_ready) begin
         checkOutput("sb_pending", 32'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            b = sb.pop_front();
            checkOutput("beat_grant", o_grant, 32'(1 << b.req));
            checkOutput("beat_data", o_data, b.data);
            checkOutput("beat_last", o_last, b.last);
         end
      end
   endtask

   task automatic setData(input int req, input logic [DWIDTH-1:0] d);
      i_data[req*DWIDTH +: DWIDTH] = d;
   endtask

   initial begin
      rstn    = 1'b0;
      i_data  = '0;
      i_valid = '0;
      i_last  = '0;
      i_ready = 1'b0;
      @(negedge clk);

      // Outputs stay quiet in reset even with every requester asking.
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkOutput("rst_valid", o_valid, 0);
      checkOutput("rst_ready", o_ready, 0);
      checkOutput("rst_grant", o_grant, 0);
      checkOutput("rst_busy", o_busy, 0);
      checkOutput("rst_data", o_data, 0);
      @(negedge clk);

      // All four request single-beat packets: grants rotate 0,1,2,3,0 with bubbles.
      rstn   = 1'b1;
      i_data = 16'hDCBA;
      expectBeat(0, 4'hA, 1'b1);
      expectBeat(1, 4'hB, 1'b1);
      expectBeat(2, 4'hC, 1'b1);
      expectBeat(3, 4'hD, 1'b1);
      expectBeat(0, 4'hA, 1'b1);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b1111, 4'b1111, 1'b1);
         checkOutput($sformatf("rr_valid_c%0d", c), o_valid, 32'(c % 2));
         @(negedge clk);
      end

      // Three-beat packet from requester 2 with a stalled beat; requester 1 waits.
      setData(2, 4'h1);
      expectBeat(2, 4'h1, 1'b0);
      expectBeat(2, 4'h2, 1'b0);
      expectBeat(2, 4'h3, 1'b1);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checkOutput("pkt_idle_valid", o_valid, 0);
      checkOutput("pkt_idle_busy", o_busy, 0);
      @(negedge clk);
      applyStimulus(4'b0110, 4'b0000, 1'b1);
      checkOutput("pkt_a_data", o_data, 4'h1);
      checkOutput("pkt_a_ready", o_ready, 4'b0100);
      @(negedge clk);
      setData(2, 4'h2);
      applyStimulus(4'b0110, 4'b0000, 1'b0);
      checkOutput("pkt_b_stall_data", o_data, 4'h2);
      checkOutput("pkt_b_stall_ready", o_ready, 4'b0000);
      @(negedge clk);
      applyStimulus(4'b0110, 4'b0000, 1'b1);
      checkOutput("pkt_b_data", o_data, 4'h2);
      checkOutput("pkt_b_grant", o_grant, 4'b0100);
      @(negedge clk);
      setData(2, 4'h3);
      applyStimulus(4'b0110, 4'b0100, 1'b1);
      checkOutput("pkt_c_data", o_data, 4'h3);
      checkOutput("pkt_c_last", o_last, 1);
      @(negedge clk);
      expectBeat(1, 4'hB, 1'b1);
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      checkOutput("turn_bubble_valid", o_valid, 0);
      checkOutput("turn_bubble_grant", o_grant, 0);
      @(negedge clk);
      applyStimulus(4'b0010, 4'b0010, 1'b1);
      checkOutput("turn_grant1", o_grant, 4'b0010);
      @(negedge clk);

      // With pointer at 1, requester 3 beats requester 0; then 0 follows.
      expectBeat(3, 4'hD, 1'b1);
      expectBeat(0, 4'hA, 1'b1);
      applyStimulus(4'b1001, 4'b1001, 1'b1);
      checkOutput("prio_idle_busy", o_busy, 0);
      @(negedge clk);
      applyStimulus(4'b1001, 4'b1001, 1'b1);
      checkOutput("prio_grant3", o_grant, 4'b1000);
      @(negedge clk);
      applyStimulus(4'b1001, 4'b1001, 1'b1);
      @(negedge clk);
      applyStimulus(4'b1001, 4'b1001, 1'b1);
      checkOutput("prio_grant0", o_grant, 4'b0001);
      @(negedge clk);

      // Granted requester 1 drops valid mid-packet; lock is held, nobody else wins.
      expectBeat(1, 4'hB, 1'b0);
      expectBeat(1, 4'hB, 1'b1);
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      @(negedge clk);
      applyStimulus(4'b0010, 4'b0000, 1'b1);
      checkOutput("gap_grant", o_grant, 4'b0010);
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(4'b1101, 4'b0000, 1'b1);
         checkOutput($sformatf("gap_valid_c%0d", c), o_valid, 0);
         checkOutput($sformatf("gap_busy_c%0d", c), o_busy, 1);
         checkOutput($sformatf("gap_hold_c%0d", c), o_grant, 4'b0010);
         @(negedge clk);
      end
      applyStimulus(4'b1111, 4'b0010, 1'b1);
      checkOutput("gap_resume_last", o_last, 1);
      @(negedge clk);

      // Reset in the middle of a packet from requester 2 drops the lock.
      expectBeat(2, 4'h3, 1'b0);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      @(negedge clk);
      applyStimulus(4'b0100, 4'b0000, 1'b1);
      checkOutput("mid_rst_grant", o_grant, 4'b0100);
      @(negedge clk);
      rstn = 1'b0;
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      checkOutput("mid_rst_valid", o_valid, 0);
      checkOutput("mid_rst_ready", o_ready, 0);
      checkOutput("mid_rst_grant0", o_grant, 0);
      checkOutput("mid_rst_busy", o_busy, 0);
      @(negedge clk);
      rstn = 1'b1;
      expectBeat(0, 4'hA, 1'b1);
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkOutput("post_rst_busy", o_busy, 0);
      checkOutput("post_rst_valid", o_valid, 0);
      @(negedge clk);
      applyStimulus(4'b1111, 4'b1111, 1'b1);
      checkOutput("post_rst_grant", o_grant, 4'b0001);
      @(negedge clk);

      // Downstream stalls for ten cycles while requester 3 holds the lock.
      expectBeat(3, 4'hD, 1'b1);
      applyStimulus(4'b1000, 4'b1000, 1'b0);
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(4'b1000, 4'b1000, 1'b0);
         checkOutput($sformatf("stall_ready_c%0d", c), o_ready, 0);
         checkOutput($sformatf("stall_data_c%0d", c), o_data, 4'hD);
         checkOutput($sformatf("stall_busy_c%0d", c), o_busy, 1);
         @(negedge clk);
      end
      applyStimulus(4'b1000, 4'b1000, 1'b1);
      checkOutput("stall_release_grant", o_grant, 4'b1000);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      checkOutput("final_idle_busy", o_busy, 0);
      @(negedge clk);

      checkOutput("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule
